// File: rtl/ddr_frame_writer_pkg.sv
// Shared types and constants for the DDR frame writer.
//   fb_state_e    : burst FSM state encoding (IDLE/ADDR/DATA)
//   widths        : pixel, word, AXI address/strobe/id/len widths
//   insert_pixel  : places one pixel into its lane of a 256-bit word
package ddr_frame_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } fb_state_e;

  localparam int PIX_PER_WORD = 16;
  localparam int PIX_W        = 16;
  localparam int WORD_W       = 256;
  localparam int AXI_ADDR_W   = 28;
  localparam int STRB_W       = 32;
  localparam int ID_W         = 4;
  localparam int LEN_W        = 4;

  // Pixel k of a word lives in bits [16k+15:16k]; the first pixel is in the LSBs.
  function automatic logic [WORD_W-1:0] insert_pixel(input logic [WORD_W-1:0] word,
                                                    input logic [3:0]        idx,
                                                    input logic [PIX_W-1:0]  pix);
    logic [WORD_W-1:0] res;
    res = word;
    res[{idx, 4'd0} +: PIX_W] = pix;
    return res;
  endfunction

endpackage

// File: rtl/ddr_frame_writer_if.sv
// AXI write-port bundle between the frame writer (master) and the ddr3_32
// controller write port (slave).
//   awaddr/awuser_ap/awuser_id/awlen/awvalid/awready : address channel
//   wdata/wstrb/wready                               : data channel
//   wusero_id/wusero_last                            : controller beat tags
interface ddr_frame_writer_if;
  import ddr_frame_writer_pkg::*;

  logic [AXI_ADDR_W-1:0] awaddr;
  logic                  awuser_ap;
  logic [ID_W-1:0]       awuser_id;
  logic [LEN_W-1:0]      awlen;
  logic                  awvalid;
  logic                  awready;
  logic [WORD_W-1:0]     wdata;
  logic [STRB_W-1:0]     wstrb;
  logic                  wready;
  logic [ID_W-1:0]       wusero_id;
  logic                  wusero_last;

  modport master (
    output awaddr, awuser_ap, awuser_id, awlen, awvalid, wdata, wstrb,
    input  awready, wready, wusero_id, wusero_last
  );

  modport slave (
    input  awaddr, awuser_ap, awuser_id, awlen, awvalid, wdata, wstrb,
    output awready, wready, wusero_id, wusero_last
  );

endinterface

// File: rtl/ddr_frame_writer_word_fifo.sv
// Synchronous word FIFO with show-ahead read (rd_data is the head entry).
//   clk, rst : clock, synchronous active-high reset
//   flush    : empties the FIFO this cycle (wins over push/pop)
//   push     : write wr_data; ignored when full unless a pop happens too
//   pop      : drop the head entry; ignored when empty
//   rd_data  : head entry, count/full/empty : occupancy status
module ddr_frame_writer_word_fifo #(
  parameter int DEPTH = 32,
  parameter int W     = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             wr_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          wr_en_s;
  logic          rd_en_s;

  assign full    = (count_r == DEPTH_C);
  assign empty   = (count_r == (AW+1)'(0));
  assign count   = count_r;
  assign rd_data = mem_r[rd_ptr_r];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign rd_en_s = pop && !empty;
  assign wr_en_s = push && (!full || rd_en_s);

  // Storage array; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (wr_en_s && !flush) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ddr_frame_writer.sv
// AXI write initiator storing an RGB565 pixel stream as a linear frame buffer.
// Packs 16 pixels per 256-bit word, buffers words, issues fixed-length bursts.
//   clk, rst     : DDR phy clock, synchronous active-high reset
//   enable       : DDR initialised; no burst starts while low
//   frame_start  : one-cycle pulse at the start of a frame
//   pix_valid/pix_data : pixel stream, no backpressure
//   axi          : AXI write port (master side)
//   busy         : FSM not idle
//   frame_done   : pulse when the last burst of a frame completes
//   overflow     : sticky, a packed word was dropped
//   proto_err    : sticky, controller beat tags disagreed with the beat count
module ddr_frame_writer
  import ddr_frame_writer_pkg::*;
#(
  parameter logic [27:0] FRAME_BASE  = 28'h0,
  parameter int          FRAME_WORDS = 57600,
  parameter int          BURST_LEN   = 8,
  parameter int          ADDR_STEP   = 8,
  parameter int          FIFO_DEPTH  = 32,
  parameter logic [3:0]  AXI_ID      = 4'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 frame_start,
  input  logic                 pix_valid,
  input  logic [PIX_W-1:0]     pix_data,
  ddr_frame_writer_if.master   axi,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overflow,
  output logic                 proto_err
);
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int WC_W = $clog2(FRAME_WORDS + 1);
  localparam logic [CW-1:0]         BURST_CNT   = CW'(BURST_LEN);
  localparam logic [3:0]            LAST_BEAT   = 4'(BURST_LEN - 1);
  localparam logic [3:0]            LAST_PIX    = 4'(PIX_PER_WORD - 1);
  localparam logic [AXI_ADDR_W-1:0] BURST_BYTES = AXI_ADDR_W'(BURST_LEN * ADDR_STEP);
  localparam logic [WC_W-1:0]       WC_BURST    = WC_W'(BURST_LEN);
  localparam logic [WC_W-1:0]       WC_FRAME    = WC_W'(FRAME_WORDS);

  fb_state_e             state_r, next_s;
  logic                  awvalid_r, busy_r, awvalid_d_s, busy_d_s;
  logic [WORD_W-1:0]     pack_r;
  logic [3:0]            pix_idx_r;
  logic [3:0]            beat_r;
  logic [AXI_ADDR_W-1:0] awaddr_r;
  logic [WC_W-1:0]       wc_r, wc_next_s;
  logic                  restart_r, frame_done_r, overflow_r, proto_err_r;
  logic                  word_full_s, push_s, drop_s, pop_s, last_beat_s, beat_err_s;
  logic                  frame_end_s, restart_now_s, idle_flush_s, flush_s;
  logic [WORD_W-1:0]     fifo_rd_s;
  logic [CW-1:0]         fifo_count_s;
  logic                  fifo_full_s, fifo_empty_s;

  // The 16th pixel goes straight into the FIFO together with the 15 held ones.
  assign word_full_s   = pix_valid && !frame_start && (pix_idx_r == LAST_PIX);
  assign push_s        = word_full_s && !restart_r;
  assign drop_s        = word_full_s && (restart_r || (fifo_full_s && !pop_s));
  assign pop_s         = (state_r == ST_DATA) && axi.wready && !fifo_empty_s;
  assign last_beat_s   = pop_s && (beat_r == LAST_BEAT);
  assign beat_err_s    = (axi.wusero_last != (beat_r == LAST_BEAT)) || (axi.wusero_id != AXI_ID);
  assign wc_next_s     = wc_r + WC_BURST;
  assign frame_end_s   = (wc_next_s == WC_FRAME);
  // A frame_start on the closing beat restarts just like one seen earlier in the burst.
  assign restart_now_s = last_beat_s && (restart_r || frame_start);
  assign idle_flush_s  = (state_r == ST_IDLE) && frame_start;
  assign flush_s       = idle_flush_s || restart_now_s;

  ddr_frame_writer_word_fifo #(.DEPTH(FIFO_DEPTH), .W(WORD_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush_s),
    .push    (push_s),
    .wr_data ({pix_data, pack_r[WORD_W-PIX_W-1:0]}),
    .pop     (pop_s),
    .rd_data (fifo_rd_s),
    .count   (fifo_count_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Pixel packer; frame_start discards any partial word.
  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      pack_r    <= {WORD_W{1'b0}};
      pix_idx_r <= 4'd0;
    end else if (pix_valid) begin
      if (pix_idx_r == LAST_PIX) begin
        pix_idx_r <= 4'd0;
      end else begin
        pack_r    <= insert_pixel(pack_r, pix_idx_r, pix_data);
        pix_idx_r <= pix_idx_r + 4'd1;
      end
    end
  end

  // FSM state register plus registered copies of the state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      awvalid_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= next_s;
      awvalid_r <= awvalid_d_s;
      busy_r    <= busy_d_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable && (fifo_count_s >= BURST_CNT) && !restart_r && !frame_start) next_s = ST_ADDR;
        else next_s = ST_IDLE;
      end
      ST_ADDR: begin
        if (axi.awready) next_s = ST_DATA;
        else next_s = ST_ADDR;
      end
      ST_DATA: begin
        if (last_beat_s) next_s = ST_IDLE;
        else next_s = ST_DATA;
      end
      default: next_s = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from the next state so they register in step with it.
  always_comb begin
    awvalid_d_s = 1'b0;
    busy_d_s    = 1'b0;
    case (next_s)
      ST_IDLE: begin
        awvalid_d_s = 1'b0;
        busy_d_s    = 1'b0;
      end
      ST_ADDR: begin
        awvalid_d_s = 1'b1;
        busy_d_s    = 1'b1;
      end
      ST_DATA: begin
        awvalid_d_s = 1'b0;
        busy_d_s    = 1'b1;
      end
      default: begin
        awvalid_d_s = 1'b0;
        busy_d_s    = 1'b0;
      end
    endcase
  end

  // Beat counter, burst address, frame word counter and deferred restart.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_r       <= 4'd0;
      awaddr_r     <= FRAME_BASE;
      wc_r         <= {WC_W{1'b0}};
      restart_r    <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      if (pop_s) beat_r <= last_beat_s ? 4'd0 : beat_r + 4'd1;
      if (last_beat_s) begin
        restart_r    <= 1'b0;
        frame_done_r <= frame_end_s;
        if (restart_now_s || frame_end_s) begin
          awaddr_r <= FRAME_BASE;
          wc_r     <= {WC_W{1'b0}};
        end else begin
          awaddr_r <= awaddr_r + BURST_BYTES;
          wc_r     <= wc_next_s;
        end
      end else if (idle_flush_s) begin
        awaddr_r  <= FRAME_BASE;
        wc_r      <= {WC_W{1'b0}};
        restart_r <= 1'b0;
      end else if (frame_start && (state_r != ST_IDLE)) begin
        restart_r <= 1'b1;
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r  <= 1'b0;
      proto_err_r <= 1'b0;
    end else begin
      if (drop_s) overflow_r <= 1'b1;
      if (pop_s && beat_err_s) proto_err_r <= 1'b1;
    end
  end

  assign axi.awaddr    = awaddr_r;
  assign axi.awuser_ap = 1'b0;
  assign axi.awuser_id = AXI_ID;
  assign axi.awlen     = LAST_BEAT;
  assign axi.awvalid   = awvalid_r;
  assign axi.wdata     = fifo_rd_s;
  assign axi.wstrb     = {STRB_W{1'b1}};
  assign busy          = busy_r;
  assign frame_done    = frame_done_r;
  assign overflow      = overflow_r;
  assign proto_err     = proto_err_r;

endmodule

// File: tb/tb_ddr_frame_writer.sv
// Self-checking bench for ddr_frame_writer: random pixel stream, a controller
// model on the AXI side, and a word-level reference of the frame buffer.
module tb_ddr_frame_writer;
  import ddr_frame_writer_pkg::*;

  localparam logic [27:0] BASE  = 28'h0;
  localparam int          FW    = 16;
  localparam int          BL    = 8;
  localparam int          STEP  = 8;
  localparam int          DEPTH = 32;
  localparam logic [3:0]  ID    = 4'h3;

  logic        clk = 1'b0;
  logic        rst, enable, frame_start, pix_valid;
  logic [15:0] pix_data;
  logic        busy, frame_done, overflow, proto_err;

  ddr_frame_writer_if axi();

  ddr_frame_writer #(
    .FRAME_BASE(BASE), .FRAME_WORDS(FW), .BURST_LEN(BL),
    .ADDR_STEP(STEP), .FIFO_DEPTH(DEPTH), .AXI_ID(ID)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_data(pix_data), .axi(axi.master),
    .busy(busy), .frame_done(frame_done), .overflow(overflow), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [255:0] exp_q[$];
  logic [255:0] acc;
  int  acc_n, burst_idx, exp_done, got_done;
  bit  exp_ovf, exp_perr, restart_pend;
  // controller model state
  int  beats_left, aw_delay, aw_wait, w_mode, bad_beat;
  bit  tog, fs_at_beat3;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] model_addr();
    return BASE + 28'(burst_idx * BL * STEP);
  endfunction

  function automatic bit w_allow();
    case (w_mode)
      0:       return 1'b1;
      1:       return tog;
      2:       return 1'b0;
      default: return ($urandom_range(0, 1) == 1);
    endcase
  endfunction

  task automatic model_pixel(input logic [15:0] p);
    acc[16*acc_n +: 16] = p;
    acc_n++;
    if (acc_n == 16) begin
      acc_n = 0;
      if (restart_pend || exp_q.size() >= DEPTH) exp_ovf = 1'b1;
      else exp_q.push_back(acc);
    end
  endtask

  // One clock: observe DUT after the edge, act as controller, drive pixels.
  task automatic step(input bit pv, input logic [15:0] pd, input bit fs);
    bit fs_auto;
    int bi;
    fs_auto = 1'b0;
    @(posedge clk); #1;
    tog = !tog;
    if (frame_done) got_done++;
    axi.wready = 1'b0; axi.wusero_last = 1'b0; axi.wusero_id = ID; axi.awready = 1'b0;
    if (!rst) begin
      if (beats_left > 0 && w_allow()) begin
        bi = BL - beats_left;
        axi.wready = 1'b1;
        axi.wusero_last = (bi == BL - 1) || (bi == bad_beat);
        if (bi == bad_beat) exp_perr = 1'b1;
        if (exp_q.size() == 0) check_val("wdata_underrun", 1, 0);
        else check_val($sformatf("wdata_beat%0d", bi), axi.wdata, exp_q.pop_front());
        if (fs_at_beat3 && bi == 3) begin
          fs_auto = 1'b1; fs_at_beat3 = 1'b0; restart_pend = 1'b1;
        end
        beats_left--;
        if (beats_left == 0) begin
          burst_idx++;
          if (burst_idx * BL == FW) begin burst_idx = 0; exp_done++; end
          if (restart_pend) begin burst_idx = 0; exp_q.delete(); restart_pend = 1'b0; end
        end
      end
      if (axi.awvalid && beats_left == 0) begin
        check_val("awaddr", axi.awaddr, model_addr());
        if (aw_wait >= aw_delay) begin
          axi.awready = 1'b1; beats_left = BL; aw_wait = 0;
        end else aw_wait++;
      end
    end
    pix_valid = pv; pix_data = pd; frame_start = fs | fs_auto;
    if (fs) begin acc_n = 0; exp_q.delete(); burst_idx = 0; end
    else if (fs_auto) acc_n = 0;
    else if (pv) model_pixel(pd);
  endtask

  task automatic send_words(input int n, input bit gaps);
    for (int w = 0; w < n; w++)
      for (int k = 0; k < 16; k++) begin
        if (gaps && $urandom_range(0, 3) == 0) step(1'b0, 16'h0, 1'b0);
        step(1'b1, 16'($urandom), 1'b0);
      end
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      step(1'b0, 16'h0, 1'b0);
      if (exp_q.size() < BL && beats_left == 0 && !restart_pend && !axi.awvalid && aw_wait == 0)
        done = 1'b1;
    end
    repeat (4) step(1'b0, 16'h0, 1'b0);
    check_val({tag, "_drained"}, done, 1);
    check_val({tag, "_awaddr"}, axi.awaddr, model_addr());
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_overflow"}, overflow, exp_ovf);
    check_val({tag, "_proto_err"}, proto_err, exp_perr);
    check_val({tag, "_frames"}, got_done, exp_done);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step(1'b0, 16'h0, 1'b0);
    rst = 1'b0;
    exp_q.delete(); acc_n = 0; burst_idx = 0;
    exp_ovf = 1'b0; exp_perr = 1'b0; restart_pend = 1'b0;
    beats_left = 0; aw_wait = 0;
    step(1'b0, 16'h0, 1'b0);
    check_val("rst_awaddr", axi.awaddr, BASE);
    check_val("rst_awvalid", axi.awvalid, 0);
    check_val("rst_awlen", axi.awlen, 4'd7);
    check_val("rst_awuser_id", axi.awuser_id, ID);
    check_val("rst_awuser_ap", axi.awuser_ap, 0);
    check_val("rst_wstrb", axi.wstrb, 32'hFFFF_FFFF);
    check_val("rst_busy", busy, 0);
    check_val("rst_frame_done", frame_done, 0);
    check_val("rst_overflow", overflow, 0);
    check_val("rst_proto_err", proto_err, 0);
  endtask

  initial begin
    int done_ref;
    rst = 1'b1; enable = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_data = 16'h0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.wusero_id = ID; axi.wusero_last = 1'b0;
    acc = '0; acc_n = 0; burst_idx = 0; exp_done = 0; got_done = 0;
    exp_ovf = 1'b0; exp_perr = 1'b0; restart_pend = 1'b0;
    beats_left = 0; aw_delay = 0; aw_wait = 0; w_mode = 0; bad_beat = -1;
    tog = 1'b0; fs_at_beat3 = 1'b0;
    do_reset();

    // 1: pixels 0..127 -> one burst at 0x0, then awaddr 0x40; awvalid two cycles after last pixel
    for (int i = 0; i < 128; i++) step(1'b1, 16'(i), 1'b0);
    step(1'b0, 16'h0, 1'b0);
    check_val("t1_awvalid_early", axi.awvalid, 0);
    step(1'b0, 16'h0, 1'b0);
    check_val("t1_awvalid_latency", axi.awvalid, 1);
    drain("t1");
    check_val("t1_next_addr", axi.awaddr, 28'h40);

    // 2: full frame of 16 words, frame_done once, next frame from FRAME_BASE
    step(1'b0, 16'h0, 1'b1);
    done_ref = got_done;
    send_words(16, 1'b1);
    drain("t2a");
    check_val("t2_one_frame_done", got_done - done_ref, 1);
    send_words(8, 1'b1);
    drain("t2b");

    // 3: awready delayed 5 cycles, wready toggling
    step(1'b0, 16'h0, 1'b1);
    aw_delay = 5; w_mode = 1;
    send_words(16, 1'b1);
    drain("t3");
    aw_delay = 0; w_mode = 0;

    // 4: frame_start during data beat 3 -> burst completes, restart at FRAME_BASE
    step(1'b0, 16'h0, 1'b1);
    w_mode = 2;
    send_words(16, 1'b0);
    fs_at_beat3 = 1'b1; w_mode = 0;
    drain("t4a");
    check_val("t4_restart_addr", axi.awaddr, BASE);
    send_words(8, 1'b0);
    drain("t4b");

    // 5: 33 words into a 32-deep FIFO with wready held low
    step(1'b0, 16'h0, 1'b1);
    w_mode = 2;
    send_words(33, 1'b0);
    repeat (3) step(1'b0, 16'h0, 1'b0);
    check_val("t5_overflow_set", overflow, 1);
    w_mode = 0;
    drain("t5");
    check_val("t5_overflow_sticky", overflow, 1);
    do_reset();

    // 6: wusero_last on beat 2 -> proto_err, burst still completes
    bad_beat = 2;
    send_words(8, 1'b1);
    drain("t6");
    check_val("t6_proto_err", proto_err, 1);
    bad_beat = -1;
    do_reset();

    // 7: random handshake timing
    for (int r = 0; r < 3; r++) begin
      aw_delay = $urandom_range(0, 3); w_mode = 3;
      send_words(8 * $urandom_range(1, 3), 1'b1);
      drain($sformatf("t7_%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
